// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed 7-segment scan driver with shadowed, frame-synchronous updates
//
// Scans N_DIGITS common-enable digits, one slot of SCAN_DIV clocks per digit.
// The first GUARD clocks of every slot are blanked so the previous digit's
// segments never ghost onto the newly enabled digit. New display data is
// captured into a shadow copy and only becomes visible at a frame boundary.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   symbols     5-bit symbol code per digit, digit i at [5i+4:5i]
//   dps         decimal point per digit (1 = lit)
//   blink_mask  per-digit blink enable
//   load        one-cycle strobe capturing symbols/dps/blink_mask
//   SEG         segment drive {a,b,c,d,e,f,g,dp}, active high, registered
//   DIG         digit enable, one-hot or zero, active high, registered
//   frame_done  one-cycle pulse in the cycle after each frame boundary
//   pending     captured data is waiting for the next frame boundary

module seg_scan_driver #(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5*N_DIGITS-1:0]   symbols,
  input  logic [N_DIGITS-1:0]     dps,
  input  logic [N_DIGITS-1:0]     blink_mask,
  input  logic                    load,
  output logic [7:0]              SEG,
  output logic [N_DIGITS-1:0]     DIG,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_MAX   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRESC_GUARD = PW'(GUARD);
  localparam logic [IW-1:0] IDX_MAX     = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BCNT_MAX    = BW'(BLINK_FRAMES - 1);
  localparam logic [5*N_DIGITS-1:0] SYM_BLANK = {N_DIGITS{5'd17}};

  // Scan state
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  // Shadow (written by load) and active (displayed) copies of the display data
  logic [5*N_DIGITS-1:0] sh_sym_q, sh_sym_d;
  logic [N_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [N_DIGITS-1:0]   sh_bm_q, sh_bm_d;
  logic [5*N_DIGITS-1:0] act_sym_q, act_sym_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [N_DIGITS-1:0]   act_bm_q, act_bm_d;
  logic                  pending_q, pending_d;

  // Registered outputs
  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] dig_q, dig_d;
  logic                frame_done_q, frame_done_d;

  logic       tick;
  logic       boundary;
  logic [4:0] cur_sym;
  logic       cur_dp;
  logic       cur_bm;
  logic [6:0] glyph;

  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] g;
    case (code)
      5'd0:    g = 7'b1111110;
      5'd1:    g = 7'b0110000;
      5'd2:    g = 7'b1101101;
      5'd3:    g = 7'b1111001;
      5'd4:    g = 7'b0110011;
      5'd5:    g = 7'b1011011;
      5'd6:    g = 7'b1011111;
      5'd7:    g = 7'b1110000;
      5'd8:    g = 7'b1111111;
      5'd9:    g = 7'b1111011;
      5'd10:   g = 7'b1110111;
      5'd11:   g = 7'b0011111;
      5'd12:   g = 7'b1001110;
      5'd13:   g = 7'b0111101;
      5'd14:   g = 7'b1001111;
      5'd15:   g = 7'b1000111;
      5'd16:   g = 7'b0110111;
      5'd18:   g = 7'b0000001;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  always_comb begin
    tick     = (presc_q == PRESC_MAX);
    boundary = tick && (idx_q == IDX_MAX);
  end

  // Prescaler, digit index and blink phase
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
    if (boundary) begin
      if (bcnt_q == BCNT_MAX) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  // Shadow/active handoff. A load landing exactly on the boundary bypasses
  // the shadow so it is never left stale behind a cleared pending flag.
  always_comb begin
    sh_sym_d  = sh_sym_q;
    sh_dp_d   = sh_dp_q;
    sh_bm_d   = sh_bm_q;
    act_sym_d = act_sym_q;
    act_dp_d  = act_dp_q;
    act_bm_d  = act_bm_q;
    pending_d = pending_q;
    if (load && boundary) begin
      act_sym_d = symbols;
      act_dp_d  = dps;
      act_bm_d  = blink_mask;
      pending_d = 1'b0;
    end else if (load) begin
      sh_sym_d  = symbols;
      sh_dp_d   = dps;
      sh_bm_d   = blink_mask;
      pending_d = 1'b1;
    end else if (boundary && pending_q) begin
      act_sym_d = sh_sym_q;
      act_dp_d  = sh_dp_q;
      act_bm_d  = sh_bm_q;
      pending_d = 1'b0;
    end
  end

  // Select the active data for the digit currently being scanned
  always_comb begin
    cur_sym = 5'd17;
    cur_dp  = 1'b0;
    cur_bm  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_sym = act_sym_q[5*i +: 5];
        cur_dp  = act_dp_q[i];
        cur_bm  = act_bm_q[i];
      end
    end
    glyph = decode(cur_sym);
  end

  always_comb begin
    seg_d        = '0;
    dig_d        = '0;
    frame_done_d = boundary;
    if (presc_q >= PRESC_GUARD) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        dig_d[i] = (idx_q == IW'(i));
      end
      // Blinked-off digits keep their enable; only the segments go dark
      if (!(phase_q && cur_bm)) begin
        seg_d = {glyph, cur_dp};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      bcnt_q       <= '0;
      phase_q      <= 1'b0;
      sh_sym_q     <= SYM_BLANK;
      sh_dp_q      <= '0;
      sh_bm_q      <= '0;
      act_sym_q    <= SYM_BLANK;
      act_dp_q     <= '0;
      act_bm_q     <= '0;
      pending_q    <= 1'b0;
      seg_q        <= '0;
      dig_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      bcnt_q       <= bcnt_d;
      phase_q      <= phase_d;
      sh_sym_q     <= sh_sym_d;
      sh_dp_q      <= sh_dp_d;
      sh_bm_q      <= sh_bm_d;
      act_sym_q    <= act_sym_d;
      act_dp_q     <= act_dp_d;
      act_bm_q     <= act_bm_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign SEG        = seg_q;
  assign DIG        = dig_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles per digit slot, minimum 4.
REQ-003 Parameter GUARD, default 2: anti-ghost blank cycles at the start of each slot, range 1..SCAN_DIV-2.
REQ-004 Parameter BLINK_FRAMES, default 64: full frames per blink half-period, minimum 1.
REQ-005 clk  in  1  single system clock; all logic is rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 symbols  in  5*N_DIGITS  5-bit symbol code per digit; digit i uses bits [5i+4:5i].
REQ-008 dps  in  N_DIGITS  decimal point per digit, 1 = lit.
REQ-009 blink_mask  in  N_DIGITS  1 = digit blinks.
REQ-010 load  in  1  one-cycle strobe that captures symbols, dps and blink_mask.
REQ-011 SEG  out  8  segment drive, active-high; [7:1] = a,b,c,d,e,f,g; [0] = dp.
REQ-012 DIG  out  N_DIGITS  digit enable, one-hot or all-zero, active-high.
REQ-013 frame_done  out  1  one-cycle pulse at each frame boundary.
REQ-014 pending  out  1  high while captured data awaits a frame boundary.

Function
REQ-015 Decoding: codes 0..15 give hex glyphs (0=1111110, 1=0110000, 8=1111111, F=1000111); 16 gives H (0110111); 17 gives blank (0000000); 18 gives dash (0000001); codes 19..31 give blank.
REQ-016 Prescaler counts 0..SCAN_DIV-1 and wraps; a tick occurs in the cycle where the prescaler equals SCAN_DIV-1.
REQ-017 Digit index advances on each tick and wraps from N_DIGITS-1 to 0.
REQ-018 Frame boundary = tick while index equals N_DIGITS-1.
REQ-019 frame_done is high for exactly the cycle after the frame boundary.
REQ-020 SEG and DIG are registered, one cycle of latency from prescaler and index.
REQ-021 While prescaler < GUARD: DIG = 0 and SEG = 0.
REQ-022 Otherwise: DIG = one-hot(index); SEG[7:1] = glyph of the active symbol[index]; SEG[0] = active dp[index].
REQ-023 Blink phase toggles each time BLINK_FRAMES frame boundaries have been counted.
REQ-024 When blink phase = 1 and the active blink_mask[index] = 1: SEG = 0 including dp, and DIG is still driven.
REQ-025 load writes the shadow registers and sets pending; a repeated load before the boundary overwrites the shadow.
REQ-026 At a frame boundary with pending set: shadow is copied to the active registers and pending clears; no mid-frame update, so no display tearing.
REQ-027 load in the same cycle as a frame boundary: the new inputs go directly to active and pending stays/clears to 0.
REQ-028 With no load outstanding, active registers hold indefinitely.

Reset
REQ-029 While rst=1 at a clk edge: prescaler=0, index=0, blink phase=0, blink counter=0, pending=0.
REQ-030 Reset also sets all active and shadow symbols to 17 (blank), dps=0, blink_mask=0, SEG=0, DIG=0, frame_done=0.
REQ-031 Reset asserted mid-frame or mid-load discards the shadow data; scanning restarts at digit 0 on the first cycle after rst deasserts.

Verification (N_DIGITS=4, SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2)
REQ-032 Reset, then idle for 32 cycles -> SEG=0 throughout; DIG cycles 0000,0001,0001,0001,0000,0010,... ; frame_done pulses every 16 cycles.
REQ-033 load with symbols {d3=16, d2=8, d1=1, d0=0} and dps=0001 mid-frame -> pending=1 until the boundary; after it, the digit-0 slot shows SEG=11111101 and the digit-3 slot shows SEG=01101110.
REQ-034 Two loads in one frame (first d0=1, then d0=15) -> only 10001110 ever appears in digit 0; 01100000 never appears.
REQ-035 load coincident with the frame boundary -> pending never rises; new glyphs appear from the next slot of digit 0.
REQ-036 blink_mask=0010 loaded with d1=8 -> digit-1 SEG alternates 11111110 for 2 frames and 00000000 for 2 frames; other digits are unaffected.
REQ-037 rst pulsed for 1 cycle during the digit-2 slot -> the next cycle gives SEG=0 and DIG=0; the following active slot is digit 0 showing blank.
